// File: rtl/ca_pkg.sv
// Shared types and defaults for the CA row streaming path.
// Holds the streamer state enum, default sizes and the word-count helper.
package ca_pkg;

    localparam int CA_ACTIVE_CELL = 128;
    localparam int CA_WORD_W      = 8;
    localparam int CA_GEN_W       = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ca_stream_state_t;

    function automatic int ca_nwords(input int cells, input int word_w);
        return cells / word_w;
    endfunction

endpackage

// File: rtl/ca_row_streamer.sv
// Snapshots each completed CA row and streams it out LSB word first over
// valid/ready, tagging rows with a generation number. One shadow row is
// being sent while a second row may wait in the pending buffer.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   ca, gen_strobe    row from the core and its single-cycle "row done" pulse
//   out_data/valid/ready/last/gen   word stream to the sink
//   drop_count        saturating count of rows lost to a full pending buffer
module ca_row_streamer
    import ca_pkg::*;
#(
    parameter int ACTIVE_CELL = CA_ACTIVE_CELL,
    parameter int WORD_W      = CA_WORD_W,
    parameter int GEN_W       = CA_GEN_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ACTIVE_CELL-1:0] ca,
    input  logic                   gen_strobe,
    output logic [WORD_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [GEN_W-1:0]       out_gen,
    output logic [GEN_W-1:0]       drop_count
);

    localparam int NWORDS = ca_nwords(ACTIVE_CELL, WORD_W);
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    if (ACTIVE_CELL % WORD_W != 0) begin : g_bad_width
        $error("ACTIVE_CELL must be a multiple of WORD_W");
    end

    ca_stream_state_t       state_q;
    logic [ACTIVE_CELL-1:0] shadow_q;
    logic [ACTIVE_CELL-1:0] pend_q;
    logic [GEN_W-1:0]       tag_q;
    logic [GEN_W-1:0]       pend_tag_q;
    logic                   pend_valid_q;
    logic [IDX_W-1:0]       idx_q;
    logic [GEN_W-1:0]       gen_q;
    logic [GEN_W-1:0]       drop_q;

    logic xfer;
    logic row_done;

    always_comb begin
        xfer     = (state_q == SEND) && out_ready;
        row_done = xfer && (idx_q == LAST_IDX);
    end

    assign out_valid  = (state_q == SEND);
    assign out_last   = (state_q == SEND) && (idx_q == LAST_IDX);
    assign out_data   = shadow_q[int'(idx_q) * WORD_W +: WORD_W];
    assign out_gen    = tag_q;
    assign drop_count = drop_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            pend_q       <= '0;
            tag_q        <= '0;
            pend_tag_q   <= '0;
            pend_valid_q <= 1'b0;
            idx_q        <= '0;
            gen_q        <= '0;
            drop_q       <= '0;
        end else begin
            // Every strobe consumes a tag, dropped rows included.
            if (gen_strobe) begin
                gen_q <= gen_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (gen_strobe) begin
                        shadow_q <= ca;
                        tag_q    <= gen_q;
                        idx_q    <= '0;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (row_done) begin
                        idx_q <= '0;
                        if (pend_valid_q) begin
                            // Pending row takes over; a coincident strobe
                            // refills the pending slot just vacated.
                            shadow_q <= pend_q;
                            tag_q    <= pend_tag_q;
                            if (gen_strobe) begin
                                pend_q     <= ca;
                                pend_tag_q <= gen_q;
                            end else begin
                                pend_valid_q <= 1'b0;
                            end
                        end else if (gen_strobe) begin
                            shadow_q <= ca;
                            tag_q    <= gen_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            idx_q <= idx_q + 1'b1;
                        end
                        if (gen_strobe) begin
                            if (!pend_valid_q) begin
                                pend_q       <= ca;
                                pend_tag_q   <= gen_q;
                                pend_valid_q <= 1'b1;
                            end else if (drop_q != '1) begin
                                drop_q <= drop_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ca_row_streamer.sv
// Directed bench for ca_row_streamer with default 128-cell, 8-bit words.
// Each comparison is an immediate assertion; a summary line ends the run.
module tb_ca_row_streamer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [127:0] ca;
    logic         gen_strobe;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [15:0]  out_gen;
    logic [15:0]  drop_count;

    int tests = 0;
    int fails = 0;

    ca_row_streamer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ca         (ca),
        .gen_strobe (gen_strobe),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_gen    (out_gen),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    logic [127:0] one64;
    logic [127:0] ramp;
    int           w;
    int           c;
    logic [15:0]  egen;
    logic [7:0]   eb;

    initial begin
        one64 = 128'd1 << 64;
        for (int k = 0; k < 16; k++) ramp[k*8 +: 8] = 8'(8'h30 + k);

        // Reset state
        reset_n    = 1'b0;
        ca         = '0;
        gen_strobe = 1'b0;
        out_ready  = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_gen", 64'(out_gen), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        reset_n = 1'b1;
        step();

        // Single row, ready held high
        out_ready  = 1'b1;
        ca         = one64;
        gen_strobe = 1'b1;
        chk("t1_pre_valid", 64'(out_valid), 64'd0);
        step();
        gen_strobe = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t1_valid%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("t1_data%0d", k), 64'(out_data),
                (k == 8) ? 64'd1 : 64'd0);
            chk($sformatf("t1_last%0d", k), 64'(out_last),
                (k == 15) ? 64'd1 : 64'd0);
            chk($sformatf("t1_gen%0d", k), 64'(out_gen), 64'd0);
            step();
        end
        chk("t1_idle", 64'(out_valid), 64'd0);
        egen = 16'd1;

        // Backpressure: ready pattern 1,0,0 repeating
        out_ready  = 1'b0;
        gen_strobe = 1'b1;
        step();
        gen_strobe = 1'b0;
        w = 0;
        c = 0;
        while (w < 16 && c < 100) begin
            out_ready = (c % 3 == 0);
            chk($sformatf("bp_valid_c%0d", c), 64'(out_valid), 64'd1);
            chk($sformatf("bp_data_c%0d", c), 64'(out_data),
                (w == 8) ? 64'd1 : 64'd0);
            chk($sformatf("bp_last_c%0d", c), 64'(out_last),
                (w == 15) ? 64'd1 : 64'd0);
            chk($sformatf("bp_gen_c%0d", c), 64'(out_gen), 64'(egen));
            if (out_ready) w++;
            step();
            c++;
        end
        out_ready = 1'b0;
        chk("bp_transfers", 64'(w), 64'd16);
        chk("bp_idle", 64'(out_valid), 64'd0);
        egen = egen + 16'd1;

        // Back-to-back rows, B strobed during A's word 3
        out_ready  = 1'b1;
        ca         = fill(8'hAA);
        gen_strobe = 1'b1;
        step();
        gen_strobe = 1'b0;
        for (int k = 0; k < 32; k++) begin
            gen_strobe = (k == 3);
            if (k == 3) ca = fill(8'h55);
            chk($sformatf("b2b_valid%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("b2b_data%0d", k), 64'(out_data),
                (k < 16) ? 64'hAA : 64'h55);
            chk($sformatf("b2b_last%0d", k), 64'(out_last),
                (k % 16 == 15) ? 64'd1 : 64'd0);
            chk($sformatf("b2b_gen%0d", k), 64'(out_gen),
                (k < 16) ? 64'(egen) : 64'(egen + 16'd1));
            step();
        end
        gen_strobe = 1'b0;
        chk("b2b_idle", 64'(out_valid), 64'd0);

        // Overflow: four strobes with the sink stalled, from a fresh reset
        reset_n   = 1'b0;
        out_ready = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ca         = fill(8'(8'h10 + k));
            gen_strobe = 1'b1;
            step();
        end
        gen_strobe = 1'b0;
        chk("ov_drop", 64'(drop_count), 64'd2);
        chk("ov_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("ov_data%0d", k), 64'(out_data),
                (k < 16) ? 64'h10 : 64'h11);
            chk($sformatf("ov_gen%0d", k), 64'(out_gen),
                (k < 16) ? 64'd0 : 64'd1);
            chk($sformatf("ov_valid%0d", k), 64'(out_valid), 64'd1);
            step();
        end
        chk("ov_idle", 64'(out_valid), 64'd0);
        ca         = fill(8'h14);
        gen_strobe = 1'b1;
        step();
        gen_strobe = 1'b0;
        chk("ov_next_gen", 64'(out_gen), 64'd4);
        chk("ov_next_data", 64'(out_data), 64'h14);
        for (int k = 0; k < 16; k++) step();
        chk("ov_drain_idle", 64'(out_valid), 64'd0);

        // Row done coinciding with a strobe while pending is full
        ca         = fill(8'h21);
        gen_strobe = 1'b1;
        step();
        gen_strobe = 1'b0;
        for (int k = 0; k < 48; k++) begin
            gen_strobe = (k == 2) || (k == 15);
            if (k == 2) ca = fill(8'h22);
            if (k == 15) ca = fill(8'h23);
            eb = 8'(8'h21 + k / 16);
            chk($sformatf("co_valid%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("co_data%0d", k), 64'(out_data), 64'(eb));
            chk($sformatf("co_gen%0d", k), 64'(out_gen), 64'(5 + k / 16));
            chk($sformatf("co_last%0d", k), 64'(out_last),
                (k % 16 == 15) ? 64'd1 : 64'd0);
            step();
        end
        gen_strobe = 1'b0;
        chk("co_idle", 64'(out_valid), 64'd0);
        chk("co_drop", 64'(drop_count), 64'd2);

        // Reset in the middle of a row
        ca         = ramp;
        gen_strobe = 1'b1;
        step();
        gen_strobe = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("mr_word7", 64'(out_data), 64'h37);
        chk("mr_gen_pre", 64'(out_gen), 64'd8);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_drop", 64'(drop_count), 64'd0);
        chk("mr_gen", 64'(out_gen), 64'd0);
        chk("mr_last", 64'(out_last), 64'd0);
        step();
        chk("mr_still_idle", 64'(out_valid), 64'd0);
        gen_strobe = 1'b1;
        step();
        gen_strobe = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("mr_re_data%0d", k), 64'(out_data),
                64'(8'h30 + k));
            chk($sformatf("mr_re_gen%0d", k), 64'(out_gen), 64'd0);
            step();
        end
        chk("mr_end_idle", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
